// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the seq_divider iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_BUSY = S_BUSY;
    localparam logic [1:0] ST_FIX  = S_FIX;
    localparam logic [1:0] ST_DONE = S_DONE;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Two's-complement magnitude of the low w bits of v; caller truncates to w bits.
    function automatic logic [63:0] abs_n(input logic [63:0] v, input int w);
        logic [63:0] res;
        if (v[w-1]) begin
            res = ~v + 64'd1;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   prem,
    input  logic [N-1:0] dvs,
    input  logic         nbit,
    output logic [N:0]   prem_next,
    output logic         q_bit
);
    localparam int W1 = N + 1;

    logic [N+1:0] shifted_s;
    logic [N+1:0] diff_s;

    assign shifted_s = {prem, nbit};
    assign diff_s    = shifted_s - {2'b00, dvs};

    // A clear MSB on the difference means the subtraction did not borrow.
    always_comb begin
        q_bit = ~diff_s[N+1];
        if (q_bit) begin
            prem_next = W1'(diff_s);
        end else begin
            prem_next = W1'(shifted_s);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider (unsigned/signed) with valid/ready handshakes.
// Optional macro SEQ_DIVIDER_ZERO_BYPASS_EN: divide-by-zero skips straight to DONE.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_by_zero
);
    localparam int CW = cnt_width(N);

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  dvd_r;
    logic [N-1:0]  dvs_r;
    logic [N:0]    prem_r;
    logic [N-1:0]  a_raw_r;
    logic          q_neg_r;
    logic          r_neg_r;
    logic          dbz_r;
    logic [N-1:0]  q_r;
    logic [N-1:0]  r_r;
    logic          dbz_out_r;

    logic [N-1:0]  a_mag_s;
    logic [N-1:0]  b_mag_s;
    logic [N:0]    prem_next_s;
    logic          q_bit_s;
    logic [N-1:0]  q_fix_s;
    logic [N-1:0]  r_fix_s;

    assign a_mag_s = mode ? N'(abs_n(64'(A), N)) : A;
    assign b_mag_s = mode ? N'(abs_n(64'(B), N)) : B;

    div_step #(.N(N)) u_step (
        .prem      (prem_r),
        .dvs       (dvs_r),
        .nbit      (dvd_r[N-1]),
        .prem_next (prem_next_s),
        .q_bit     (q_bit_s)
    );

    // Sign fix-up of the magnitudes; a zero divisor forces the all-ones / dividend result.
    always_comb begin
        q_fix_s = dvd_r;
        r_fix_s = prem_r[N-1:0];
        if (dbz_r) begin
            q_fix_s = {N{1'b1}};
            r_fix_s = a_raw_r;
        end else begin
            if (q_neg_r) begin
                q_fix_s = {N{1'b0}} - dvd_r;
            end else begin
                q_fix_s = dvd_r;
            end
            if (r_neg_r) begin
                r_fix_s = {N{1'b0}} - prem_r[N-1:0];
            end else begin
                r_fix_s = prem_r[N-1:0];
            end
        end
    end

    // FSM and datapath: dvd_r shifts dividend bits out and quotient bits in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            dvd_r     <= {N{1'b0}};
            dvs_r     <= {N{1'b0}};
            prem_r    <= {(N+1){1'b0}};
            a_raw_r   <= {N{1'b0}};
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            dbz_r     <= 1'b0;
            q_r       <= {N{1'b0}};
            r_r       <= {N{1'b0}};
            dbz_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_raw_r <= A;
                        dvd_r   <= a_mag_s;
                        dvs_r   <= b_mag_s;
                        prem_r  <= {(N+1){1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        q_neg_r <= mode & (A[N-1] ^ B[N-1]);
                        r_neg_r <= mode & A[N-1];
                        dbz_r   <= (B == {N{1'b0}});
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
                        if (B == {N{1'b0}}) begin
                            q_r       <= {N{1'b1}};
                            r_r       <= A;
                            dbz_out_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            state_r   <= ST_BUSY;
                        end
`else
                        state_r <= ST_BUSY;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    prem_r <= prem_next_s;
                    dvd_r  <= {dvd_r[N-2:0], q_bit_s};
                    cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CW'(N - 1)) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_FIX: begin
                    q_r       <= q_fix_s;
                    r_r       <= r_fix_s;
                    dbz_out_r <= dbz_r;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_r == ST_IDLE);
    assign out_valid   = (state_r == ST_DONE);
    assign Q           = q_r;
    assign R           = r_r;
    assign div_by_zero = dbz_out_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N = 8).
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic       mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] Q;
    logic [7:0] R;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 10;
`endif

    seq_divider #(.N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .mode        (mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one division, check latency and result, optionally stall the consumer.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic md, input logic [7:0] eq, input logic [7:0] er,
                           input logic ez, input int elat, input int stall, input logic hold_rdy);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        A = a;
        B = b;
        mode = md;
        in_valid = 1'b1;
        out_ready = hold_rdy;
        tick();
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        mode = 1'($urandom);
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            A = 8'($urandom);
            B = 8'($urandom);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_Q"}, 32'(Q), 32'(eq));
        chk({tag, "_R"}, 32'(R), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_Q"}, 32'(Q), 32'(eq));
            chk({tag, "_stall_R"}, 32'(R), 32'(er));
            chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Q", 32'(Q), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);

        run_div("u200_7",   8'd200, 8'd7,   1'b0, 8'h1C, 8'h04, 1'b0, 10, 0, 1'b0);
        run_div("s_m100_7", 8'h9C,  8'h07,  1'b1, 8'hF2, 8'hFE, 1'b0, 10, 0, 1'b0);
        run_div("s_100_m7", 8'h64,  8'hF9,  1'b1, 8'hF2, 8'h02, 1'b0, 10, 0, 1'b1);
        run_div("dbz_u",    8'h55,  8'h00,  1'b0, 8'hFF, 8'h55, 1'b1, ZLAT, 0, 1'b0);
        run_div("dbz_s",    8'h55,  8'h00,  1'b1, 8'hFF, 8'h55, 1'b1, ZLAT, 0, 1'b0);
        run_div("s_ovf",    8'h80,  8'hFF,  1'b1, 8'h80, 8'h00, 1'b0, 10, 0, 1'b0);
        run_div("u_ovfops", 8'h80,  8'hFF,  1'b0, 8'h00, 8'h80, 1'b0, 10, 0, 1'b0);
        run_div("u_ff_1",   8'hFF,  8'h01,  1'b0, 8'hFF, 8'h00, 1'b0, 10, 0, 1'b0);

        // Backpressure followed immediately by a second division.
        run_div("bp_240_15", 8'hF0, 8'h0F,  1'b0, 8'h10, 8'h00, 1'b0, 10, 5, 1'b0);
        run_div("b2b_127_5", 8'h7F, 8'h05,  1'b1, 8'h19, 8'h02, 1'b0, 10, 0, 1'b0);

        // Reset during iteration 3 of a division.
        A = 8'd200;
        B = 8'd7;
        mode = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_Q", 32'(Q), 32'd0);
        chk("midrst_R", 32'(R), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("midrst_no_stale", 32'(seen), 32'd0);
        end
        run_div("u100_10", 8'd100, 8'd10, 1'b0, 8'h0A, 8'h00, 1'b0, 10, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
